// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: imem fetch handshake and decode-side valid/stall bundle
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_stall;
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ready, imem_rvalid, imem_rdata, id_stall
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ready, imem_rvalid, imem_rdata, id_stall
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, next-PC generation and single-outstanding instruction fetch
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        npc_op,
  input  logic [31:0]       redir_pc,
  input  logic [31:0]       br_imm,
  input  logic [25:0]       j_idx,
  input  logic [31:0]       rs_data,
  fetch_pc_unit_if.master   bus,
  output logic              misalign
);
  localparam logic [1:0] NPC_PLUS4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH   = 2'd1;
  localparam logic [1:0] NPC_JUMP_IMM = 2'd2;
  localparam logic [1:0] NPC_JUMP_REG = 2'd3;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic [31:0] seq4, target;
  logic        misalign_q, misalign_d, redirect, accept, capture;
  // redirect target; register jumps are forced word aligned
  always_comb begin
    seq4   = redir_pc + 32'd4;
    target = npc_op == NPC_BRANCH   ? seq4 + (br_imm << 2) :
             npc_op == NPC_JUMP_IMM ? {seq4[31:28], j_idx, 2'b00} :
             npc_op == NPC_JUMP_REG ? {rs_data[31:2], 2'b00} : seq4;
  end
  // fetch sequencer: a redirect always wins, and any response still owed is drained
  always_comb begin
    redirect   = npc_op != NPC_PLUS4;
    accept     = bus.imem_req & bus.imem_ready;
    capture    = (state_q == S_WAIT) & bus.imem_rvalid & !redirect;
    state_d    = state_q;
    case (state_q)
      S_REQ:   state_d = accept ? (redirect ? S_DRAIN : S_WAIT) : S_REQ;
      S_WAIT:  state_d = bus.imem_rvalid ? (redirect ? S_REQ : S_HOLD) : (redirect ? S_DRAIN : S_WAIT);
      S_HOLD:  state_d = (redirect || !bus.id_stall) ? S_REQ : S_HOLD;
      S_DRAIN: state_d = bus.imem_rvalid ? S_REQ : S_DRAIN;
      default: state_d = S_REQ;
    endcase
    pc_d       = redirect ? target : capture ? pc_q + 32'd4 : pc_q;
    if_pc_d    = capture ? pc_q : if_pc_q;
    if_instr_d = capture ? bus.imem_rdata : if_instr_q;
    misalign_d = misalign_q | ((npc_op == NPC_JUMP_REG) & (|rs_data[1:0]));
  end
  // state and PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end
  assign bus.imem_req  = (state_q == S_REQ) && !rst;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = state_q == S_HOLD;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign misalign      = misalign_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: vector table, corner sequences and random traffic against a transaction model
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  npc_op = '0;
  logic [31:0] redir_pc = '0, br_imm = '0, rs_data = '0;
  logic [25:0] j_idx = '0;
  logic        misalign;
  fetch_pc_unit_if bus();
  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .npc_op(npc_op), .redir_pc(redir_pc), .br_imm(br_imm),
    .j_idx(j_idx), .rs_data(rs_data), .bus(bus), .misalign(misalign)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [25:0] j;
    logic [31:0] rs;
    logic [31:0] addr;
    logic        mis;
  } vec_t;
  vec_t        vt [9];
  int          checks = 0, failures = 0, delivered = 0, resp_cnt = 0, lat = 1;
  logic [31:0] resp_addr = '0, exp_fetch = RST_PC, pend_addr = '0, hold_addr = '0, last_addr = '0;
  bit          pend = 0, mis_m = 0, hold_prev = 0, last_acc = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [31:0] ref_target();
    case (npc_op)
      2'd1:    return redir_pc + 32'd4 + br_imm * 4;
      2'd2:    return ((redir_pc + 32'd4) & 32'hF000_0000) | ({6'b0, j_idx} * 4);
      2'd3:    return rs_data & ~32'd3;
      default: return redir_pc + 32'd4;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    bit acc;
    bus.imem_rvalid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem(resp_addr);
      end
    end
    #1;
    acc       = bus.imem_req & bus.imem_ready;
    last_acc  = acc;
    last_addr = bus.imem_addr;
    if (rst) begin
      exp_fetch = RST_PC; pend = 0; mis_m = 0; hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("req_held", {31'b0, bus.imem_req}, 32'd1);
        chk("addr_held", bus.imem_addr, hold_addr);
      end
      hold_prev = bus.imem_req & !bus.imem_ready & (npc_op == 2'd0);
      hold_addr = bus.imem_addr;
      if (acc) begin
        chk("fetch_addr", bus.imem_addr, exp_fetch);
        resp_cnt  = lat;
        resp_addr = bus.imem_addr;
      end
      if (bus.if_valid & !bus.id_stall & (npc_op == 2'd0)) begin
        pend = 0;
        delivered++;
      end
      if (npc_op != 2'd0) begin
        exp_fetch = ref_target();
        pend = 0;
      end else if (acc) begin
        pend = 1; pend_addr = bus.imem_addr; exp_fetch = bus.imem_addr + 32'd4;
      end
      if (npc_op == 2'd3 && rs_data[1:0] != 2'd0) mis_m = 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      chk("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
      chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
      chk("rst_if_pc", bus.if_pc, 32'd0);
      chk("rst_if_instr", bus.if_instr, 32'd0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
    end else begin
      chk("misalign", {31'b0, misalign}, {31'b0, mis_m});
      if (bus.if_valid) begin
        chk("if_valid_legal", {31'b0, pend}, 32'd1);
        chk("if_pc", bus.if_pc, pend_addr);
        chk("if_instr", bus.if_instr, mem(pend_addr));
      end
    end
  endtask
  initial begin
    logic [31:0] got [3];
    logic [31:0] held_pc, held_instr, a0;
    logic [31:0] r;
    int n;
    bit saw_valid;
    vt[0] = '{2'd1, 32'h0000_3010, 32'hFFFF_FFFE, 26'h0,       32'h0,      32'h0000_300C, 1'b0};
    vt[1] = '{2'd2, 32'h0000_0000, 32'h0,        26'h0000C04, 32'h0,      32'h0000_3010, 1'b0};
    vt[2] = '{2'd2, 32'hF000_0000, 32'h0,        26'h3FFFFFF, 32'h0,      32'hFFFF_FFFC, 1'b0};
    vt[3] = '{2'd3, 32'h0,         32'h0,        26'h0,       32'h4000,   32'h0000_4000, 1'b0};
    vt[4] = '{2'd1, 32'hFFFF_FFFC, 32'h0,        26'h0,       32'h0,      32'h0000_0000, 1'b0};
    vt[5] = '{2'd1, 32'h0000_1000, 32'h10,       26'h0,       32'h0,      32'h0000_1044, 1'b0};
    vt[6] = '{2'd2, 32'hEFFF_FFFC, 32'h0,        26'h1,       32'h0,      32'hF000_0004, 1'b0};
    vt[7] = '{2'd3, 32'h0,         32'h0,        26'h0,       32'h4002,   32'h0000_4000, 1'b1};
    vt[8] = '{2'd1, 32'h0,         32'h0,        26'h0,       32'h0,      32'h0000_0004, 1'b1};
    bus.imem_ready = 1'b1; bus.id_stall = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (i == 0) chk("if_valid_post_rst", {31'b0, bus.if_valid}, 32'd0);
      if (last_acc) begin got[n] = last_addr; n++; end
    end
    chk("first_fetch_count", n, 3);
    chk("first_addr0", got[0], 32'h3000);
    chk("first_addr1", got[1], 32'h3004);
    chk("first_addr2", got[2], 32'h3008);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.imem_req; i++) step();
    chk("table_wait_req", {31'b0, bus.imem_req}, 32'd1);
    foreach (vt[k]) begin
      npc_op = vt[k].op; redir_pc = vt[k].rpc; br_imm = vt[k].imm; j_idx = vt[k].j; rs_data = vt[k].rs;
      step();
      npc_op = 2'd0;
      chk($sformatf("vec%0d_addr", k), bus.imem_addr, vt[k].addr);
      chk($sformatf("vec%0d_misalign", k), {31'b0, misalign}, {31'b0, vt[k].mis});
    end
    rst = 1'b1; step(); rst = 1'b0;
    bus.imem_ready = 1'b1; lat = 3; last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) step();
    chk("wait_accept", {31'b0, last_acc}, 32'd1);
    npc_op = 2'd3; rs_data = 32'h4000;
    step();
    npc_op = 2'd0; saw_valid = 0; last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) begin
      step();
      saw_valid |= bus.if_valid;
    end
    chk("stale_dropped", {31'b0, saw_valid}, 32'd0);
    chk("redir_wait_addr", last_addr, 32'h4000);
    lat = 1;
    for (int i = 0; i < 20 && !bus.if_valid; i++) step();
    chk("stall_wait_valid", {31'b0, bus.if_valid}, 32'd1);
    bus.id_stall = 1'b1; held_pc = bus.if_pc; held_instr = bus.if_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_if_pc", bus.if_pc, held_pc);
      chk("stall_if_instr", bus.if_instr, held_instr);
      chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
      chk("stall_valid", {31'b0, bus.if_valid}, 32'd1);
    end
    bus.id_stall = 1'b0; last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) step();
    chk("post_stall_addr", last_addr, held_pc + 32'd4);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 20 && !bus.imem_req; i++) step();
    a0 = bus.imem_addr;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("notready_req", {31'b0, bus.imem_req}, 32'd1);
      chk("notready_addr", bus.imem_addr, a0);
    end
    bus.imem_ready = 1'b1;
    step();
    chk("ready_accept", {31'b0, last_acc}, 32'd1);
    chk("ready_accept_addr", last_addr, a0);
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      bus.imem_ready = $urandom_range(0, 3) != 0;
      bus.id_stall   = $urandom_range(0, 2) == 0;
      lat            = $urandom_range(1, 3);
      rst            = $urandom_range(0, 399) == 0;
      npc_op         = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      redir_pc       = $urandom & ~32'd3;
      r              = $urandom;
      br_imm         = {{16{r[15]}}, r[15:0]};
      j_idx          = 26'($urandom);
      rs_data        = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
      step();
    end
    rst = 1'b0; npc_op = 2'd0; bus.id_stall = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("random_progress", {31'b0, delivered > 100}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
